mem_bus_ctrl: RTL and testbench



---
 rtl/mem_bus_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl
//   Processor-side initiator for the main-memory bus. Arbitrates between the
//   icache fetch port and the dcache load/store port, issues one bus command
//   at a time, and tracks outstanding load tags so tagged return data is
//   routed back to the owning port together with that port's request ID.
//
// Ports
//   clk, rst                      clock, async active-high reset
//   ic_req_*                      icache load request (vld/addr/id in, rdy out)
//   dc_req_*                      dcache request (vld/cmd/addr/data/id in, rdy out)
//   ic_rsp_*, dc_rsp_*            registered load-data return pulses per port
//   dc_st_ack_o, dc_st_id_o       store accepted by memory (pulse)
//   proc2mem_*                    bus command/address/store data (registered)
//   mem2proc_response_i           nonzero = command accepted, value = tag
//   mem2proc_tag_i/data_i         nonzero tag = data belongs to that tag
//   outst_cnt_o                   loads currently outstanding
//   err_o                         protocol error pulse (bad return / tag reuse)
// -----------------------------------------------------------------------------
module mem_bus_ctrl #(
  parameter int ID_W       = 4,
  parameter int MAX_OUTST  = 8,   // 1..15
  parameter int STARVE_LIM = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ic_req_vld_i,
  input  logic [63:0]     ic_req_addr_i,
  input  logic [ID_W-1:0] ic_req_id_i,
  output logic            ic_req_rdy_o,
  input  logic            dc_req_vld_i,
  input  logic [1:0]      dc_req_cmd_i,
  input  logic [63:0]     dc_req_addr_i,
  input  logic [63:0]     dc_req_data_i,
  input  logic [ID_W-1:0] dc_req_id_i,
  output logic            dc_req_rdy_o,
  output logic            ic_rsp_vld_o,
  output logic [ID_W-1:0] ic_rsp_id_o,
  output logic [63:0]     ic_rsp_data_o,
  output logic            dc_rsp_vld_o,
  output logic [ID_W-1:0] dc_rsp_id_o,
  output logic [63:0]     dc_rsp_data_o,
  output logic            dc_st_ack_o,
  output logic [ID_W-1:0] dc_st_id_o,
  output logic [1:0]      proc2mem_command_o,
  output logic [63:0]     proc2mem_addr_o,
  output logic [63:0]     proc2mem_data_o,
  input  logic [3:0]      mem2proc_response_i,
  input  logic [63:0]     mem2proc_data_i,
  input  logic [3:0]      mem2proc_tag_i,
  output logic [3:0]      outst_cnt_o,
  output logic            err_o
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  localparam int            SW         = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
  localparam logic [3:0]    MAX_CNT    = 4'(MAX_OUTST);

  // owner encoding in the tag table: 0 = icache, 1 = dcache
  logic [0:0]      r_state;
  logic [1:0]      r_cmd;       // doubles as the bus command: NONE outside ISSUE
  logic [63:0]     r_addr;
  logic [63:0]     r_data;
  logic [ID_W-1:0] r_id;
  logic            r_owner;
  logic [3:0]      r_cnt;
  logic [SW-1:0]   r_starve;

  logic            r_tbl_vld [16];
  logic            r_tbl_own [16];
  logic [ID_W-1:0] r_tbl_id  [16];

  logic            r_ic_rsp_vld, r_dc_rsp_vld, r_st_ack, r_err;
  logic [ID_W-1:0] r_ic_rsp_id, r_dc_rsp_id, r_st_id;
  logic [63:0]     r_ic_rsp_data, r_dc_rsp_data;

  // ---------------------------------------------------------------- arbitration
  logic w_idle, w_full, w_dc_ld, w_dc_st, w_dc_ok, w_ic_ok, w_ic_gnt, w_dc_gnt;

  assign w_idle  = (r_state == S_IDLE);
  // A load is admitted only while it still fits under MAX_OUTST; stores never
  // allocate a tag so they ignore this.
  assign w_full  = (r_cnt >= MAX_CNT);
  assign w_dc_ld = dc_req_vld_i && (dc_req_cmd_i == CMD_LOAD);
  assign w_dc_st = dc_req_vld_i && (dc_req_cmd_i == CMD_STORE);
  assign w_dc_ok = w_dc_st || (w_dc_ld && !w_full);
  assign w_ic_ok = ic_req_vld_i && !w_full;

  // dcache has priority unless icache has been passed over STARVE_LIM times.
  assign w_ic_gnt = w_idle && w_ic_ok && (!w_dc_ok || (r_starve == STARVE_MAX));
  assign w_dc_gnt = w_idle && w_dc_ok && !w_ic_gnt;

  assign ic_req_rdy_o = w_ic_gnt;
  assign dc_req_rdy_o = w_dc_gnt;

  // ---------------------------------------------------------------- tag bookkeeping
  logic w_rsp, w_alloc, w_st_done, w_ret, w_ret_hit, w_ret_miss, w_same, w_dup, w_inc;

  assign w_rsp      = (r_state == S_ISSUE) && (mem2proc_response_i != 4'd0);
  assign w_alloc    = w_rsp && (r_cmd == CMD_LOAD);
  assign w_st_done  = w_rsp && (r_cmd == CMD_STORE);
  assign w_ret      = (mem2proc_tag_i != 4'd0);
  assign w_ret_hit  = w_ret && r_tbl_vld[mem2proc_tag_i];
  assign w_ret_miss = w_ret && !r_tbl_vld[mem2proc_tag_i];
  // A return on the very tag being allocated frees it first, so that is not reuse.
  assign w_same     = w_ret_hit && (mem2proc_tag_i == mem2proc_response_i);
  assign w_dup      = w_alloc && r_tbl_vld[mem2proc_response_i] && !w_same;
  // An overwrite of a live entry leaves the count alone.
  assign w_inc      = w_alloc && !w_dup;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        r_tbl_vld[i] <= 1'b0;
        r_tbl_own[i] <= 1'b0;
        r_tbl_id[i]  <= '0;
      end
    end else begin
      if (w_ret_hit) r_tbl_vld[mem2proc_tag_i] <= 1'b0;
      // Later assignment wins, so a same-tag return+allocate keeps the new entry.
      if (w_alloc) begin
        r_tbl_vld[mem2proc_response_i] <= 1'b1;
        r_tbl_own[mem2proc_response_i] <= r_owner;
        r_tbl_id[mem2proc_response_i]  <= r_id;
      end
    end
  end

  // The count equals the number of live entries in a 15-entry table, so it
  // cannot exceed 15 nor go below 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= 4'd0;
    else     r_cnt <= r_cnt + 4'(w_inc) - 4'(w_ret_hit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (!ic_req_vld_i || w_ic_gnt) begin
      r_starve <= '0;
    end else if (w_dc_gnt && (r_starve != STARVE_MAX)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // ---------------------------------------------------------------- FSM / bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cmd   <= CMD_NONE;
      r_addr  <= '0;
      r_data  <= '0;
      r_id    <= '0;
      r_owner <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ic_gnt) begin
            r_state <= S_ISSUE;
            r_cmd   <= CMD_LOAD;
            r_addr  <= ic_req_addr_i;
            r_data  <= '0;
            r_id    <= ic_req_id_i;
            r_owner <= 1'b0;
          end else if (w_dc_gnt) begin
            r_state <= S_ISSUE;
            r_cmd   <= dc_req_cmd_i;
            r_addr  <= dc_req_addr_i;
            r_data  <= dc_req_data_i;
            r_id    <= dc_req_id_i;
            r_owner <= 1'b1;
          end
        end
        default: begin
          if (w_rsp) begin
            r_state <= S_IDLE;
            r_cmd   <= CMD_NONE;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ic_rsp_vld  <= 1'b0;
      r_ic_rsp_id   <= '0;
      r_ic_rsp_data <= '0;
      r_dc_rsp_vld  <= 1'b0;
      r_dc_rsp_id   <= '0;
      r_dc_rsp_data <= '0;
      r_st_ack      <= 1'b0;
      r_st_id       <= '0;
      r_err         <= 1'b0;
    end else begin
      r_ic_rsp_vld <= w_ret_hit && !r_tbl_own[mem2proc_tag_i];
      r_dc_rsp_vld <= w_ret_hit &&  r_tbl_own[mem2proc_tag_i];
      if (w_ret_hit && !r_tbl_own[mem2proc_tag_i]) begin
        r_ic_rsp_id   <= r_tbl_id[mem2proc_tag_i];
        r_ic_rsp_data <= mem2proc_data_i;
      end
      if (w_ret_hit && r_tbl_own[mem2proc_tag_i]) begin
        r_dc_rsp_id   <= r_tbl_id[mem2proc_tag_i];
        r_dc_rsp_data <= mem2proc_data_i;
      end
      r_st_ack <= w_st_done;
      if (w_st_done) r_st_id <= r_id;
      r_err <= w_ret_miss || w_dup;
    end
  end

  assign ic_rsp_vld_o       = r_ic_rsp_vld;
  assign ic_rsp_id_o        = r_ic_rsp_id;
  assign ic_rsp_data_o      = r_ic_rsp_data;
  assign dc_rsp_vld_o       = r_dc_rsp_vld;
  assign dc_rsp_id_o        = r_dc_rsp_id;
  assign dc_rsp_data_o      = r_dc_rsp_data;
  assign dc_st_ack_o        = r_st_ack;
  assign dc_st_id_o         = r_st_id;
  assign proc2mem_command_o = r_cmd;
  assign proc2mem_addr_o    = r_addr;
  assign proc2mem_data_o    = r_data;
  assign outst_cnt_o        = r_cnt;
  assign err_o              = r_err;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Random stimulus against a tag-map reference model. The stimulus process plays
// both the caches and the memory; it pushes expected response/ack/error pulses
// (with their due cycle) into a queue, and a forked monitor pops them when the
// DUT pulses.
module tb_mem_bus_ctrl;
  localparam int ID_W       = 4;
  localparam int MAX_OUTST  = 8;
  localparam int STARVE_LIM = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            ic_req_vld_i;
  logic [63:0]     ic_req_addr_i;
  logic [ID_W-1:0] ic_req_id_i;
  logic            ic_req_rdy_o;
  logic            dc_req_vld_i;
  logic [1:0]      dc_req_cmd_i;
  logic [63:0]     dc_req_addr_i;
  logic [63:0]     dc_req_data_i;
  logic [ID_W-1:0] dc_req_id_i;
  logic            dc_req_rdy_o;
  logic            ic_rsp_vld_o;
  logic [ID_W-1:0] ic_rsp_id_o;
  logic [63:0]     ic_rsp_data_o;
  logic            dc_rsp_vld_o;
  logic [ID_W-1:0] dc_rsp_id_o;
  logic [63:0]     dc_rsp_data_o;
  logic            dc_st_ack_o;
  logic [ID_W-1:0] dc_st_id_o;
  logic [1:0]      proc2mem_command_o;
  logic [63:0]     proc2mem_addr_o;
  logic [63:0]     proc2mem_data_o;
  logic [3:0]      mem2proc_response_i;
  logic [63:0]     mem2proc_data_i;
  logic [3:0]      mem2proc_tag_i;
  logic [3:0]      outst_cnt_o;
  logic            err_o;

  mem_bus_ctrl #(.ID_W(ID_W), .MAX_OUTST(MAX_OUTST), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .rst(rst),
    .ic_req_vld_i(ic_req_vld_i), .ic_req_addr_i(ic_req_addr_i), .ic_req_id_i(ic_req_id_i),
    .ic_req_rdy_o(ic_req_rdy_o),
    .dc_req_vld_i(dc_req_vld_i), .dc_req_cmd_i(dc_req_cmd_i), .dc_req_addr_i(dc_req_addr_i),
    .dc_req_data_i(dc_req_data_i), .dc_req_id_i(dc_req_id_i), .dc_req_rdy_o(dc_req_rdy_o),
    .ic_rsp_vld_o(ic_rsp_vld_o), .ic_rsp_id_o(ic_rsp_id_o), .ic_rsp_data_o(ic_rsp_data_o),
    .dc_rsp_vld_o(dc_rsp_vld_o), .dc_rsp_id_o(dc_rsp_id_o), .dc_rsp_data_o(dc_rsp_data_o),
    .dc_st_ack_o(dc_st_ack_o), .dc_st_id_o(dc_st_id_o),
    .proc2mem_command_o(proc2mem_command_o), .proc2mem_addr_o(proc2mem_addr_o),
    .proc2mem_data_o(proc2mem_data_o),
    .mem2proc_response_i(mem2proc_response_i), .mem2proc_data_i(mem2proc_data_i),
    .mem2proc_tag_i(mem2proc_tag_i),
    .outst_cnt_o(outst_cnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;   // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 ic_rsp, 1 dc_rsp, 2 st_ack, 3 err
  typedef struct {
    int              kind;
    logic [ID_W-1:0] id;
    logic [63:0]     data;
    int              cyc;
  } exp_t;
  exp_t  q_exp[$];
  string knd_nm[4] = '{"ic_rsp", "dc_rsp", "st_ack", "err"};

  int tests = 0;
  int fails = 0;

  // reference model: which tags memory holds for whom, plus the pending command
  bit              m_vld[16];
  bit              m_own[16];
  logic [ID_W-1:0] m_id[16];
  int              m_cnt, m_starve, m_wait;
  bit              m_busy, m_pown;
  logic [1:0]      m_cmd;
  logic [63:0]     m_addr, m_data;
  logic [ID_W-1:0] m_pid;
  bit              ic_pend, dc_pend;

  // stimulus knobs (percentages)
  int p_ic, p_dc, p_st, p_bad, p_ret, p_err, p_dup, max_wait, force_rtag;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input logic [ID_W-1:0] id, input logic [63:0] d, input int c);
    exp_t e;
    // both error causes in one cycle still give a single pulse
    if (k == 3) foreach (q_exp[i]) if (q_exp[i].kind == 3 && q_exp[i].cyc == c) return;
    e.kind = k; e.id = id; e.data = d; e.cyc = c;
    q_exp.push_back(e);
  endtask

  function automatic logic [3:0] pick_tag(input bit want_valid);
    int cand[$];
    for (int t = 1; t < 16; t++) if (m_vld[t] == want_valid) cand.push_back(t);
    if (cand.size() == 0) return 4'd0;
    return 4'(cand[$urandom_range(cand.size() - 1)]);
  endfunction

  task automatic mon_cycle();
    bit              v[4];
    logic [ID_W-1:0] ids[4];
    logic [63:0]     ds[4];
    int              idx;
    v[0] = ic_rsp_vld_o; ids[0] = ic_rsp_id_o; ds[0] = ic_rsp_data_o;
    v[1] = dc_rsp_vld_o; ids[1] = dc_rsp_id_o; ds[1] = dc_rsp_data_o;
    v[2] = dc_st_ack_o;  ids[2] = dc_st_id_o;  ds[2] = '0;
    v[3] = err_o;        ids[3] = '0;          ds[3] = '0;
    for (int k = 0; k < 4; k++) begin
      idx = -1;
      for (int i = 0; i < q_exp.size(); i++)
        if (q_exp[i].kind == k) begin idx = i; break; end
      if (v[k]) begin
        if (idx < 0) begin
          tests++; fails++;
          $display("FAIL %s: unexpected pulse id=%0h data=%0h at cycle %0d, expected none",
                   knd_nm[k], ids[k], ds[k], cyc);
        end else begin
          chk({knd_nm[k], " cycle"}, 64'(cyc), 64'(q_exp[idx].cyc));
          if (k < 3) chk({knd_nm[k], " id"}, 64'(ids[k]), 64'(q_exp[idx].id));
          if (k < 2) chk({knd_nm[k], " data"}, ds[k], q_exp[idx].data);
          q_exp.delete(idx);
        end
      end else if (idx >= 0 && q_exp[idx].cyc <= cyc) begin
        tests++; fails++;
        $display("FAIL %s: no pulse at cycle %0d, expected id=%0h data=%0h",
                 knd_nm[k], q_exp[idx].cyc, q_exp[idx].id, q_exp[idx].data);
        q_exp.delete(idx);
      end
    end
  endtask

  task automatic model_clear();
    for (int t = 0; t < 16; t++) m_vld[t] = 1'b0;
    m_cnt = 0; m_starve = 0; m_busy = 1'b0; m_wait = 0;
    ic_pend = 1'b0; dc_pend = 1'b0;
  endtask

  // One clock: check state left by the previous edge, drive inputs for the
  // next edge, and predict what that edge does.
  task automatic step();
    logic [3:0]  resp, rtag;
    logic [63:0] rdata;
    bit          full, ic_ok, dc_ok, ic_g, dc_g;
    int          e, r;
    @(posedge clk); #1;
    e = cyc + 1;
    chk("outst_cnt", 64'(outst_cnt_o), 64'(m_cnt));
    chk("bus_cmd", 64'(proc2mem_command_o), m_busy ? 64'(m_cmd) : 64'd0);
    if (m_busy) begin
      chk("bus_addr", proc2mem_addr_o, m_addr);
      if (m_cmd == 2'd2) chk("bus_data", proc2mem_data_o, m_data);
    end

    // cache requests are held until accepted; bad dcache commands last one cycle
    if (!ic_pend && $urandom_range(99) < p_ic) begin
      ic_pend = 1'b1;
      ic_req_addr_i = {$urandom, $urandom};
      ic_req_id_i = ID_W'($urandom);
    end
    ic_req_vld_i = ic_pend;
    if (!dc_pend && $urandom_range(99) < p_dc) begin
      dc_pend = 1'b1;
      r = $urandom_range(99);
      if (r < p_bad) dc_req_cmd_i = r[0] ? 2'd0 : 2'd3;
      else dc_req_cmd_i = ($urandom_range(99) < p_st) ? 2'd2 : 2'd1;
      dc_req_addr_i = {$urandom, $urandom};
      dc_req_data_i = {$urandom, $urandom};
      dc_req_id_i = ID_W'($urandom);
    end
    dc_req_vld_i = dc_pend;

    // memory: accept the pending command after a random delay
    resp = 4'd0;
    if (m_busy) begin
      if (m_wait > 0) m_wait--;
      else if (m_cmd == 2'd1)
        resp = (m_cnt > 0 && $urandom_range(99) < p_dup) ? pick_tag(1'b1) : pick_tag(1'b0);
      else
        resp = 4'($urandom_range(15, 1));
    end
    rtag = 4'd0;
    if (force_rtag != 0) rtag = 4'(force_rtag);
    else if ($urandom_range(99) < p_err) rtag = pick_tag(1'b0);
    else if (resp != 0 && m_cmd == 2'd1 && m_vld[resp] && $urandom_range(1) == 1) rtag = resp;
    else if (m_cnt > 0 && $urandom_range(99) < p_ret) rtag = pick_tag(1'b1);
    rdata = {$urandom, $urandom};
    mem2proc_response_i = resp;
    mem2proc_tag_i = rtag;
    mem2proc_data_i = rdata;
    #1;

    // expected arbitration outcome
    full  = (m_cnt >= MAX_OUTST);
    ic_ok = ic_req_vld_i && !full;
    dc_ok = dc_req_vld_i && (dc_req_cmd_i == 2'd2 || (dc_req_cmd_i == 2'd1 && !full));
    ic_g  = !m_busy && ic_ok && (!dc_ok || m_starve == STARVE_LIM);
    dc_g  = !m_busy && dc_ok && !ic_g;
    chk("ic_req_rdy", 64'(ic_req_rdy_o), 64'(ic_g));
    chk("dc_req_rdy", 64'(dc_req_rdy_o), 64'(dc_g));

    if (!ic_req_vld_i || ic_g) m_starve = 0;
    else if (dc_g && m_starve < STARVE_LIM) m_starve++;

    // return first, then allocation (same-tag case reuses the freed slot)
    if (rtag != 0) begin
      if (m_vld[rtag]) begin
        push(m_own[rtag] ? 1 : 0, m_id[rtag], rdata, e);
        m_vld[rtag] = 1'b0;
        m_cnt--;
      end else push(3, '0, '0, e);
    end
    if (resp != 0) begin
      if (m_cmd == 2'd1) begin
        if (m_vld[resp]) push(3, '0, '0, e);
        else m_cnt++;
        m_vld[resp] = 1'b1; m_own[resp] = m_pown; m_id[resp] = m_pid;
      end else push(2, m_pid, '0, e);
      m_busy = 1'b0;
    end

    if (ic_g) begin
      m_busy = 1'b1; m_cmd = 2'd1; m_addr = ic_req_addr_i; m_pid = ic_req_id_i;
      m_pown = 1'b0; ic_pend = 1'b0; m_wait = $urandom_range(max_wait);
    end
    if (dc_g) begin
      m_busy = 1'b1; m_cmd = dc_req_cmd_i; m_addr = dc_req_addr_i; m_data = dc_req_data_i;
      m_pid = dc_req_id_i; m_pown = 1'b1; dc_pend = 1'b0; m_wait = $urandom_range(max_wait);
    end
    if (dc_pend && (dc_req_cmd_i == 2'd0 || dc_req_cmd_i == 2'd3)) dc_pend = 1'b0;
  endtask

  task automatic knobs(input int ic, input int dc, input int st, input int bad,
                       input int ret, input int er, input int dup, input int mw);
    p_ic = ic; p_dc = dc; p_st = st; p_bad = bad;
    p_ret = ret; p_err = er; p_dup = dup; max_wait = mw;
  endtask

  initial begin
    int          n, old_tag;
    rst = 1'b1;
    ic_req_vld_i = 1'b0; ic_req_addr_i = '0; ic_req_id_i = '0;
    dc_req_vld_i = 1'b0; dc_req_cmd_i = '0; dc_req_addr_i = '0; dc_req_data_i = '0; dc_req_id_i = '0;
    mem2proc_response_i = '0; mem2proc_data_i = '0; mem2proc_tag_i = '0;
    force_rtag = 0;
    model_clear();
    knobs(0, 0, 0, 0, 0, 0, 0, 0);
    fork
      forever begin
        @(negedge clk);
        if (!rst) mon_cycle();
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset cmd", 64'(proc2mem_command_o), 64'd0);
    chk("reset addr", proc2mem_addr_o, 64'd0);
    chk("reset cnt", 64'(outst_cnt_o), 64'd0);
    chk("reset rsp", 64'({ic_rsp_vld_o, dc_rsp_vld_o, dc_st_ack_o, err_o}), 64'd0);
    rst = 1'b0;

    // mixed traffic, including bad commands, stray returns and tag reuse
    knobs(40, 50, 40, 10, 30, 3, 3, 3);
    repeat (800) step();
    // both ports hammering with a fast memory: exercises the starvation limit
    knobs(100, 100, 50, 0, 60, 0, 0, 0);
    repeat (200) step();
    // no returns: table fills to MAX_OUTST, then only stores get through
    knobs(100, 100, 20, 0, 0, 0, 0, 1);
    repeat (80) step();
    knobs(100, 100, 20, 0, 30, 0, 0, 1);
    repeat (100) step();

    // steer to: three loads outstanding, a load in ISSUE, nothing pending
    n = 0;
    while (!(m_busy && m_cmd == 2'd1 && m_cnt == 3 && q_exp.size() == 0) && n < 400) begin
      if (m_cnt > 3) knobs(0, 0, 0, 0, 50, 0, 0, 0);
      else if (m_cnt < 3) knobs(0, 100, 0, 0, 0, 0, 0, 0);
      else knobs(0, 100, 0, 0, 0, 0, 0, 6);
      step();
      n++;
    end
    if (n >= 400) begin
      tests++; fails++;
      $display("FAIL reset_setup: steps=%0d, expected a busy load with 3 outstanding within 400", n);
    end
    @(posedge clk); #1;
    ic_req_vld_i = 1'b0; dc_req_vld_i = 1'b0;
    mem2proc_response_i = '0; mem2proc_tag_i = '0;
    chk("pre-reset cnt", 64'(outst_cnt_o), 64'(m_cnt));
    chk("pre-reset cmd", 64'(proc2mem_command_o), m_busy ? 64'(m_cmd) : 64'd0);
    old_tag = pick_tag(1'b1);
    rst = 1'b1;
    #1;
    chk("mid reset cmd", 64'(proc2mem_command_o), 64'd0);
    chk("mid reset cnt", 64'(outst_cnt_o), 64'd0);
    chk("mid reset rdy", 64'({ic_req_rdy_o, dc_req_rdy_o}), 64'd0);
    chk("mid reset rsp", 64'({ic_rsp_vld_o, dc_rsp_vld_o, dc_st_ack_o, err_o}), 64'd0);
    model_clear();
    q_exp.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // a return for a tag issued before reset is now an error
    knobs(0, 0, 0, 0, 0, 0, 0, 0);
    force_rtag = old_tag;
    step();
    force_rtag = 0;
    repeat (3) step();

    // short burst, then drain every outstanding load
    knobs(40, 50, 40, 10, 30, 3, 3, 3);
    repeat (150) step();
    knobs(0, 0, 0, 0, 100, 0, 0, 1);
    repeat (40) step();
    @(negedge clk); #1;
    chk("leftover expectations", 64'(q_exp.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
